// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master: it drives req/addr and receives ack/rdata.
interface fetch_stage_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID register: one outstanding halfword fetch, decode stalls,
// branch redirect with bubble insertion.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | first cycle after reset, no request issued
// FETCH    | request at pc outstanding (or issued this cycle)
// HOLD     | fetched word parked in hold buffer while decode is stalled
// DISCARD  | waiting out a request made stale by a redirect; data dropped
module fetch_stage #(
    parameter int               ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]       NOP_INSTR = 16'hBF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master     imem,
    output logic [15:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] HALF_MASK = ~ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
    logic [15:0]       hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [15:0]       if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic              if_id_valid_q, if_id_valid_d;

    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_inc;

    assign redir_pc = redirect_pc & HALF_MASK;
    assign pc_inc   = pc_q + ADDR_W'(2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC & HALF_MASK;
            disc_addr_q   <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            disc_addr_q   <= disc_addr_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        disc_addr_d   = disc_addr_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        pc_d          = redir_pc;
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end else if (stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = pc_q;
                        pc_d         = pc_inc;
                        state_d      = ST_HOLD;
                    end else begin
                        if_id_instr_d = imem.imem_rdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_inc;
                    end
                end else if (redirect) begin
                    // Request is still in flight; keep presenting its address until acked.
                    disc_addr_d   = pc_q;
                    pc_d          = redir_pc;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    state_d       = ST_DISCARD;
                end else if (!stall) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end
            ST_DISCARD: begin
                if (redirect) pc_d = redir_pc;
                if (redirect || !stall) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
                if (imem.imem_ack) state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d          = redir_pc;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (!stall) begin
                    if_id_instr_d = hold_instr_q;
                    if_id_pc_d    = hold_pc_q;
                    if_id_valid_d = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        case (state_q)
            ST_FETCH:   imem.imem_req = 1'b1;
            ST_DISCARD: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = disc_addr_q;
            end
            default:    imem.imem_req = 1'b0;
        endcase
    end

    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a simple imem model with programmable wait states.
// Memory word at address a is 16'h2001 + (a>>1)*16'h0101.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;

    int n_pass;
    int n_total;
    int mem_wait;
    int cnt;

    fetch_stage_if #(.ADDR_W(16)) ifc ();

    fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000), .NOP_INSTR(16'hBF00)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (ifc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        logic [15:0] idx;
        idx = a >> 1;
        return 16'h2001 + idx * 16'h0101;
    endfunction

    assign ifc.imem_ack   = ifc.imem_req && (cnt == mem_wait);
    assign ifc.imem_rdata = mem_data(ifc.imem_addr);

    always @(posedge clk or negedge reset) begin
        if (!reset)                             cnt <= 0;
        else if (ifc.imem_req && !ifc.imem_ack) cnt <= cnt + 1;
        else                                    cnt <= 0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", ifc.imem_req); else n_pass++;
        n_total++; if (if_id_instr !== 16'hBF00) $display("FAIL rst_instr: got %h want bf00", if_id_instr); else n_pass++;
        n_total++; if (if_id_pc !== 16'h0000) $display("FAIL rst_pc: got %h want 0000", if_id_pc); else n_pass++;
        n_total++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", if_id_valid); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", ifc.imem_req); else n_pass++;
    endtask

    task automatic test_stream;
        tick();
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0000) $display("FAIL stream_a0: got req %b addr %h want 1 0000", ifc.imem_req, ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_valid !== 1'b0) $display("FAIL stream_v0: got %b want 0", if_id_valid); else n_pass++;
        tick();
        n_total++; if (ifc.imem_addr !== 16'h0002) $display("FAIL stream_a2: got %h want 0002", ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_instr !== 16'h2001 || if_id_pc !== 16'h0000 || if_id_valid !== 1'b1) $display("FAIL stream_i0: got %h/%h/%b want 2001/0000/1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
        tick();
        n_total++; if (ifc.imem_addr !== 16'h0004) $display("FAIL stream_a4: got %h want 0004", ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_instr !== 16'h2102 || if_id_pc !== 16'h0002) $display("FAIL stream_i2: got %h/%h want 2102/0002", if_id_instr, if_id_pc); else n_pass++;
    endtask

    task automatic test_stall;
        tick();
        n_total++; if (if_id_instr !== 16'h2203 || ifc.imem_addr !== 16'h0006) $display("FAIL stall_pre: got %h addr %h want 2203 0006", if_id_instr, ifc.imem_addr); else n_pass++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (ifc.imem_req !== 1'b0 || if_id_instr !== 16'h2203 || if_id_pc !== 16'h0004) $display("FAIL stall_hold%0d: got req %b %h/%h want 0 2203/0004", i, ifc.imem_req, if_id_instr, if_id_pc); else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_total++; if (if_id_instr !== 16'h2304 || if_id_pc !== 16'h0006 || if_id_valid !== 1'b1) $display("FAIL stall_rel: got %h/%h/%b want 2304/0006/1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0008) $display("FAIL stall_resume: got req %b addr %h want 1 0008", ifc.imem_req, ifc.imem_addr); else n_pass++;
        tick();
        n_total++; if (if_id_instr !== 16'h2405 || if_id_pc !== 16'h0008) $display("FAIL stall_next: got %h/%h want 2405/0008", if_id_instr, if_id_pc); else n_pass++;
    endtask

    task automatic test_redirect_ack;
        redirect = 1'b1;
        redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0040) $display("FAIL redir_addr: got req %b addr %h want 1 0040", ifc.imem_req, ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_instr !== 16'hBF00 || if_id_valid !== 1'b0) $display("FAIL redir_flush: got %h/%b want bf00/0", if_id_instr, if_id_valid); else n_pass++;
        tick();
        n_total++; if (if_id_instr !== 16'h4021 || if_id_pc !== 16'h0040 || if_id_valid !== 1'b1) $display("FAIL redir_tgt: got %h/%h/%b want 4021/0040/1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
    endtask

    task automatic test_wait_redirect;
        mem_wait = 2;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0042 || if_id_valid !== 1'b0) $display("FAIL wr_disc1: got req %b addr %h v %b want 1 0042 0", ifc.imem_req, ifc.imem_addr, if_id_valid); else n_pass++;
        tick();
        n_total++; if (ifc.imem_addr !== 16'h0042 || if_id_valid !== 1'b0) $display("FAIL wr_disc2: got addr %h v %b want 0042 0", ifc.imem_addr, if_id_valid); else n_pass++;
        tick();
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0100) $display("FAIL wr_newreq: got req %b addr %h want 1 0100", ifc.imem_req, ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_instr !== 16'hBF00 || if_id_valid !== 1'b0) $display("FAIL wr_drop: got %h/%b want bf00/0", if_id_instr, if_id_valid); else n_pass++;
        repeat (2) tick();
        n_total++; if (ifc.imem_addr !== 16'h0100 || if_id_valid !== 1'b0) $display("FAIL wr_wait: got addr %h v %b want 0100 0", ifc.imem_addr, if_id_valid); else n_pass++;
        tick();
        n_total++; if (if_id_instr !== 16'hA081 || if_id_pc !== 16'h0100 || if_id_valid !== 1'b1) $display("FAIL wr_tgt: got %h/%h/%b want a081/0100/1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
    endtask

    task automatic test_wrap;
        mem_wait = 0;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        n_total++; if (ifc.imem_addr !== 16'hFFFE) $display("FAIL wrap_top: got %h want fffe", ifc.imem_addr); else n_pass++;
        tick();
        n_total++; if (ifc.imem_addr !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_instr !== 16'h9F00 || if_id_pc !== 16'hFFFE || if_id_valid !== 1'b1) $display("FAIL wrap_instr: got %h/%h/%b want 9f00/fffe/1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
        tick();
        n_total++; if (if_id_instr !== 16'h2001 || if_id_pc !== 16'h0000 || ifc.imem_addr !== 16'h0002) $display("FAIL wrap_after: got %h/%h addr %h want 2001/0000 0002", if_id_instr, if_id_pc, ifc.imem_addr); else n_pass++;
    endtask

    task automatic test_hold_redirect;
        stall = 1'b1;
        tick();
        n_total++; if (ifc.imem_req !== 1'b0 || if_id_instr !== 16'h2001) $display("FAIL hr_hold: got req %b %h want 0 2001", ifc.imem_req, if_id_instr); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0200) $display("FAIL hr_addr: got req %b addr %h want 1 0200", ifc.imem_req, ifc.imem_addr); else n_pass++;
        n_total++; if (if_id_instr !== 16'hBF00 || if_id_valid !== 1'b0) $display("FAIL hr_flush: got %h/%b want bf00/0", if_id_instr, if_id_valid); else n_pass++;
        tick();
        n_total++; if (if_id_instr !== 16'h2101 || if_id_pc !== 16'h0200 || if_id_valid !== 1'b1) $display("FAIL hr_tgt: got %h/%h/%b want 2101/0200/1", if_id_instr, if_id_pc, if_id_valid); else n_pass++;
    endtask

    task automatic test_reset_midreq;
        mem_wait = 3;
        tick();
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_ack !== 1'b0) $display("FAIL mr_pending: got req %b ack %b want 1 0", ifc.imem_req, ifc.imem_ack); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (ifc.imem_req !== 1'b0 || if_id_instr !== 16'hBF00 || if_id_valid !== 1'b0) $display("FAIL mr_rst: got req %b %h/%b want 0 bf00/0", ifc.imem_req, if_id_instr, if_id_valid); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0000) $display("FAIL mr_restart: got req %b addr %h want 1 0000", ifc.imem_req, ifc.imem_addr); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        mem_wait = 0;
        reset = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_ack();
        test_wait_redirect();
        test_wrap();
        test_hold_redirect();
        test_reset_midreq();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
